// File: rtl/seg_mux_driver_if.sv
// seg_mux_driver_if: display-value staging inputs and multiplexed display outputs
interface seg_mux_driver_if;
  logic [1:0] muxcount;
  logic [15:0] value_in;
  logic [3:0] dp_in;
  logic load;
  logic [3:0] blink_en;
  logic pending;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp;
  modport master(output muxcount, value_in, dp_in, load, blink_en, input pending, an, seg, dp);
  modport slave(input muxcount, value_in, dp_in, load, blink_en, output pending, an, seg, dp);
endinterface

// File: rtl/seg_mux_driver.sv
// seg_mux_driver: double-buffered 4-digit multiplexed seven-segment driver
module seg_mux_driver #(
  parameter int BLINK_BITS = 6,
  parameter bit LZ_BLANK = 1'b1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic clk,
  input logic res,
  seg_mux_driver_if.slave bus
);
  // hex glyphs {g..a}, digit n at bits [7n +: 7]
  localparam logic [111:0] HEX = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                  7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  localparam logic [3:0] AN_OFF = {4{ACTIVE_LOW}};
  localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};
  logic [15:0] disp_val_q, disp_val_d, stage_val_q, stage_val_d, upper;
  logic [3:0] disp_dp_q, disp_dp_d, stage_dp_q, stage_dp_d, nib;
  logic pending_q, pending_d, frame_end, lz, blank;
  logic [BLINK_BITS-1:0] frame_q, frame_d;
  logic [1:0] k;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d;
  always_comb begin
    k = bus.muxcount;
    frame_end = k == 2'd3;
    stage_val_d = bus.load ? bus.value_in : stage_val_q;
    stage_dp_d = bus.load ? bus.dp_in : stage_dp_q;
    pending_d = bus.load | (pending_q & ~frame_end);
    disp_val_d = (frame_end & pending_q) ? stage_val_q : disp_val_q;
    disp_dp_d = (frame_end & pending_q) ? stage_dp_q : disp_dp_q;
    frame_d = frame_q + BLINK_BITS'(frame_end);
    // the digit is leading-zero blank when it and every higher nibble are zero
    upper = disp_val_q >> {k, 2'b00};
    lz = LZ_BLANK && k != 2'd0 && upper == 16'd0;
    blank = lz | (bus.blink_en[k] & frame_q[BLINK_BITS-1]);
    nib = disp_val_q[{k, 2'b00} +: 4];
    an_d = blank ? AN_OFF : (4'b0001 << k) ^ AN_OFF;
    seg_d = blank ? SEG_OFF : HEX[nib * 7 +: 7] ^ SEG_OFF;
    dp_d = blank ? ACTIVE_LOW : disp_dp_q[k] ^ ACTIVE_LOW;
  end
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      disp_val_q <= '0;
      disp_dp_q <= '0;
      stage_val_q <= '0;
      stage_dp_q <= '0;
      pending_q <= 1'b0;
      frame_q <= '0;
      an_q <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q <= ACTIVE_LOW;
    end else begin
      disp_val_q <= disp_val_d;
      disp_dp_q <= disp_dp_d;
      stage_val_q <= stage_val_d;
      stage_dp_q <= stage_dp_d;
      pending_q <= pending_d;
      frame_q <= frame_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
    end
  end
  assign bus.pending = pending_q;
  assign bus.an = an_q;
  assign bus.seg = seg_q;
  assign bus.dp = dp_q;
endmodule

// File: tb/tb_seg_mux_driver.sv
// tb_seg_mux_driver: directed vectors for the multiplexed seven-segment driver
module tb_seg_mux_driver;
  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;
  seg_mux_driver_if bus();
  seg_mux_driver #(.BLINK_BITS(2), .LZ_BLANK(1'b1), .ACTIVE_LOW(1'b1)) dut (.clk(clk), .res(res), .bus(bus));
  typedef struct {
    logic [15:0] val;
    logic [3:0] dpe;
    logic [3:0][6:0] seg;
    logic [3:0] blank;
  } vec_t;
  vec_t tbl [7];
  int errors = 0;
  int checks = 0;
  int frames = 0;
  logic [1:0] mc_prev;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // one clock; the counter model advances muxcount and the frame count like the upstream counter
  task automatic tick;
    @(posedge clk);
    #1;
    mc_prev = bus.muxcount;
    if (mc_prev == 2'd3) frames++;
    bus.muxcount = bus.muxcount + 2'd1;
    bus.load = 1'b0;
  endtask
  task automatic chk_digit(input string tag, input logic blank, input logic [6:0] s, input logic dpe);
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic dp_e;
    an_e = blank ? 4'hF : ~(4'b0001 << mc_prev);
    seg_e = blank ? 7'h7F : s;
    dp_e = blank ? 1'b1 : ~dpe;
    chk($sformatf("%s an d%0d", tag, mc_prev), 32'(bus.an), 32'(an_e));
    chk($sformatf("%s seg d%0d", tag, mc_prev), 32'(bus.seg), 32'(seg_e));
    chk($sformatf("%s dp d%0d", tag, mc_prev), 32'(bus.dp), 32'(dp_e));
  endtask
  task automatic run_frame(input string tag, input logic [3:0][6:0] s, input logic [3:0] blank, input logic [3:0] dpe);
    repeat (4) begin
      tick;
      chk_digit(tag, blank[mc_prev], s[mc_prev], dpe[mc_prev]);
    end
  endtask
  task automatic load_val(input logic [15:0] v, input logic [3:0] d);
    bus.value_in = v;
    bus.dp_in = d;
    bus.load = 1'b1;
    tick;
    chk($sformatf("pending after load %h", v), 32'(bus.pending), 32'h1);
  endtask
  task automatic wait_commit(input string tag);
    for (int i = 0; i < 8 && bus.pending; i++) tick;
    chk($sformatf("%s pending cleared", tag), 32'(bus.pending), 32'h0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{16'h12AF, 4'b0100, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b0000};
    tbl[1] = '{16'h0000, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110};
    tbl[2] = '{16'h8888, 4'b1010, {7'h00, 7'h00, 7'h00, 7'h00}, 4'b0000};
    tbl[3] = '{16'h0345, 4'b1111, {7'h7F, 7'h30, 7'h19, 7'h12}, 4'b1000};
    tbl[4] = '{16'h00C0, 4'b0001, {7'h7F, 7'h7F, 7'h46, 7'h40}, 4'b1100};
    tbl[5] = '{16'h0D07, 4'b0010, {7'h7F, 7'h21, 7'h40, 7'h78}, 4'b1000};
    tbl[6] = '{16'h6B9E, 4'b1001, {7'h02, 7'h03, 7'h10, 7'h06}, 4'b0000};
    res = 1'b1;
    bus.muxcount = 2'd3;
    bus.load = 1'b0;
    bus.value_in = '0;
    bus.dp_in = '0;
    bus.blink_en = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset an", 32'(bus.an), 32'hF);
    chk("reset seg", 32'(bus.seg), 32'h7F);
    chk("reset dp", 32'(bus.dp), 32'h1);
    chk("reset pending", 32'(bus.pending), 32'h0);
    @(negedge clk) res = 1'b0;
    tick;
    chk_digit("post-reset", 1'b1, 7'h7F, 1'b0);
    tick;
    chk_digit("post-reset", 1'b0, 7'h40, 1'b0);
    repeat (3) begin
      tick;
      chk_digit("post-reset", 1'b1, 7'h7F, 1'b0);
    end
    for (int i = 0; i < 7; i++) begin
      load_val(tbl[i].val, tbl[i].dpe);
      wait_commit($sformatf("vec%0d", i));
      run_frame($sformatf("vec%0d", i), tbl[i].seg, tbl[i].blank, tbl[i].dpe);
    end
    // new value must not appear before the frame boundary
    load_val(16'h8888, 4'b0000);
    wait_commit("show8");
    run_frame("show8", {7'h00, 7'h00, 7'h00, 7'h00}, 4'b0000, 4'b0000);
    load_val(16'h0000, 4'b0000);
    chk_digit("hold8", 1'b0, 7'h00, 1'b0);
    repeat (3) begin
      tick;
      chk_digit("hold8", 1'b0, 7'h00, 1'b0);
    end
    chk("hold8 committed", 32'(bus.pending), 32'h0);
    run_frame("zero", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110, 4'b0000);
    // load coincident with frame end
    load_val(16'h1111, 4'b0000);
    chk_digit("coin pre", 1'b0, 7'h40, 1'b0);
    repeat (2) begin
      tick;
      chk_digit("coin pre", 1'b1, 7'h7F, 1'b0);
    end
    bus.value_in = 16'h2222;
    bus.load = 1'b1;
    tick;
    chk_digit("coin edge", 1'b1, 7'h7F, 1'b0);
    chk("coin pending stays", 32'(bus.pending), 32'h1);
    run_frame("coin 1111", {7'h79, 7'h79, 7'h79, 7'h79}, 4'b0000, 4'b0000);
    chk("coin pending cleared", 32'(bus.pending), 32'h0);
    run_frame("coin 2222", {7'h24, 7'h24, 7'h24, 7'h24}, 4'b0000, 4'b0000);
    // blink: phase is bit 1 of the frame count
    bus.blink_en = 4'b0001;
    load_val(16'h0005, 4'b0000);
    wait_commit("blink");
    for (int f = 0; f < 8; f++) run_frame($sformatf("blink f%0d", f), {7'h7F, 7'h7F, 7'h7F, 7'h12}, {3'b111, frames[1]}, 4'b0000);
    bus.blink_en = 4'b0000;
    // asynchronous reset with a value staged
    load_val(16'h9999, 4'b1111);
    #2;
    res = 1'b1;
    #1;
    chk("async an", 32'(bus.an), 32'hF);
    chk("async seg", 32'(bus.seg), 32'h7F);
    chk("async dp", 32'(bus.dp), 32'h1);
    chk("async pending", 32'(bus.pending), 32'h0);
    frames = 0;
    bus.muxcount = 2'd3;
    @(negedge clk) res = 1'b0;
    tick;
    chk_digit("after async", 1'b1, 7'h7F, 1'b0);
    tick;
    chk_digit("after async", 1'b0, 7'h40, 1'b0);
    chk("after async pending", 32'(bus.pending), 32'h0);
    repeat (3) begin
      tick;
      chk_digit("after async", 1'b1, 7'h7F, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_mux_driver.md
Name: seg_mux_driver

Overview:
- Downstream consumer of the 2-bit digit-select counter (`muxcount`). Drives a 4-digit multiplexed seven-segment display.
- Holds a 16-bit hex value in a double-buffered register. New values are applied only at frame boundaries, so the display never tears.
- Decodes the selected nibble, applies leading-zero and per-digit blink blanking, and produces registered anode, segment and decimal-point outputs.

Parameters:
- BLINK_BITS, 6, width of the frame counter; its MSB is the blink phase.
- LZ_BLANK, 1, 1 enables leading-zero blanking on digits 3..1.
- ACTIVE_LOW, 1, 1 means an/seg/dp are driven active-low; 0 means active-high.

Ports:
- clk  input  1  system clock; same clock as the digit-select counter.
- res  input  1  asynchronous, active-high reset.
- muxcount  input  2  current digit select; k selects digit k.
- value_in  input  16  hex value to display; digit k = value_in[4k+3:4k].
- dp_in  input  4  decimal-point enables, bit k for digit k.
- load  input  1  one-cycle strobe; captures value_in and dp_in.
- blink_en  input  4  per-digit blink enable.
- pending  output  1  1 while a staged value is waiting for the frame boundary.
- an  output  4  digit anodes.
- seg  output  7  segments {g,f,e,d,c,b,a}.
- dp  output  1  decimal point.

Behaviour:
- Reset (async, res=1):
  - disp_val=0, disp_dp=0, stage_val=0, stage_dp=0, pending=0, frame counter=0.
  - an, seg and dp at their inactive level: all 1s when ACTIVE_LOW=1, all 0s otherwise.
- frame_end = (muxcount==3). It is sampled each clk edge.
- Staging:
  - load=1: stage_val<=value_in, stage_dp<=dp_in, pending<=1.
  - Back-to-back loads: the last one wins.
- Commit:
  - On an edge with frame_end=1 and pending=1 (value pre-edge): disp_val<=stage_val, disp_dp<=stage_dp.
  - pending<=0, unless load=1 on the same edge.
- Simultaneous load and frame_end:
  - The previously staged value commits (if pending was 1).
  - The new value enters staging.
  - pending=1 afterwards.
  - The new value displays at the next frame_end.
- Frame counter:
  - Increments by 1 on every edge with frame_end=1.
  - Wraps modulo 2^BLINK_BITS.
  - blink_phase = counter MSB.
- Digit k = muxcount. Digit k is blanked if either condition holds:
  - blink_en[k]=1 and blink_phase=1; or
  - LZ_BLANK=1, k≥1, and disp_val nibbles k..3 are all zero.
  - Digit 0 is never LZ-blanked (a value of 0 shows "0").
- Output register, 1-cycle latency. Outputs at edge n+1 reflect muxcount, disp_val, disp_dp and blink_phase sampled at edge n.
  - Not blanked: an = one-hot on bit k; seg = hex decode of the nibble; dp = disp_dp[k].
  - Blanked: an, seg and dp all inactive.
  - All values are polarity-inverted when ACTIVE_LOW=1.
- Hex decode, active-high {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Digit-select counter reset value is 3. The first post-reset output cycle therefore shows digit 3, and the first edge after reset is a frame_end.
- Reset asserted mid-frame or with pending=1:
  - Staged data is discarded.
  - Outputs go inactive immediately, without waiting for clk.
- Any muxcount sequence is accepted. Nothing assumes muxcount increments by exactly 1.

Test Plan:
- Reset then release, ACTIVE_LOW=1, muxcount cycling 3,0,1,2: first output is an=1111 (digit 3 LZ-blanked); digit 0 shows an=1110, seg=1000000.
- load value_in=16'h12AF, dp_in=4'b0100 while muxcount=1: pending=1. After the muxcount=3 edge, pending=0. Next frame shows:
  - digit0 seg=0001110 (F)
  - digit1 seg=0001000 (A)
  - digit2 seg=0100100 with dp=0 (2 with point)
  - digit3 seg=1111001 (1)
- Commit timing: load 16'h0000 at muxcount=0 while 16'h8888 is displayed. Digits 1 and 2 of that frame still show 8 (seg=0000000). Only after the muxcount=3 edge does the next frame show digit0 "0" and digits 1..3 an=1111.
- Load and frame_end coincident: pending=1 with stage=16'h1111; load 16'h2222 on the muxcount=3 edge. The next frame shows 1111 and pending stays 1. The following frame shows 2222 and pending=0.
- Blink: BLINK_BITS=2, blink_en=4'b0001, value 16'h0005. Digit 0 shows for 2 frames, blanked (an=1111) for 2 frames, and repeats. Digits 1..3 stay LZ-blanked throughout.
- Async reset mid-frame with pending=1: outputs go inactive within the same cycle. After release, pending=0 and the display shows 0 (digit 0 only).
